// File: rtl/uart_dbg_master.sv
// UART debug bridge: 8N1 command frames on RXD drive single 32-bit bus reads/writes; results return on TXD.
// Optional inter-byte timeout for partial frames is compiled in with UART_DBG_TIMEOUT_EN.
module uart_dbg_master #(
  parameter int BAUD    = 868,
  parameter int TIMEOUT = 1000000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RXD,
  output logic        TXD,
  output logic [31:0] ADDR,
  output logic        RD,
  output logic        WR,
  output logic [3:0]  BE,
  output logic [31:0] DATAO,
  input  logic [31:0] DATAI,
  input  logic        HLT,
  output logic        ACTIVE,
  output logic        ERR
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_ADDR = 3'd1;
  localparam logic [2:0] P_DATA = 3'd2;
  localparam logic [2:0] P_BUS  = 3'd3;
  localparam logic [2:0] P_RESP = 3'd4;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_BAD = 8'h3F;

  // ---------------------------------------------------------------- receiver
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start that is no longer low at mid-bit was a glitch: drop it quietly.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rxd_sync_q;
          rx_ferr_d  = !rxd_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ------------------------------------------------------------- transmitter
  // Bit index 0 is START, 1..8 are D0..D7, 9 is STOP; busy=0 is IDLE.
  logic          tx_busy_q, tx_busy_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          txd_q, txd_d;
  logic          tx_load;
  logic [7:0]    tx_byte;
  logic          tx_done, tx_ready;

  assign tx_done  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_END);
  // Accepting a new byte as the stop bit ends keeps consecutive characters gap-free.
  assign tx_ready = !tx_busy_q || tx_done;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    txd_d      = txd_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          txd_d     = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
    if (tx_load && tx_ready) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      txd_d      = 1'b0;
      tx_shift_d = {1'b1, tx_byte};
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      txd_q      <= txd_d;
    end
  end

  // ------------------------------------------------------------ frame parser
  logic [2:0]  p_state_q, p_state_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] datao_q, datao_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign tx_byte = resp_q[31:24];

  always_comb begin
    p_state_d   = p_state_q;
    cmd_wr_d    = cmd_wr_q;
    byte_cnt_d  = byte_cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    addr_d      = addr_q;
    datao_d     = datao_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    be_d        = be_q;
    err_d       = rx_ferr_q;
    tx_load     = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (rx_valid_q) begin
          byte_cnt_d = '0;
          if (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD) begin
            cmd_wr_d  = (rx_shift_q == CMD_WR);
            p_state_d = P_ADDR;
          end else begin
            resp_d      = {RESP_BAD, 24'h0};
            resp_left_d = 3'd1;
            err_d       = 1'b1;
            p_state_d   = P_RESP;
          end
        end
      end
      P_ADDR: begin
        if (rx_valid_q) begin
          addr_sh_d  = {addr_sh_q[23:0], rx_shift_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) p_state_d = cmd_wr_q ? P_DATA : P_BUS;
        end
      end
      P_DATA: begin
        if (rx_valid_q) begin
          data_sh_d  = {data_sh_q[23:0], rx_shift_q};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) p_state_d = P_BUS;
        end
      end
      P_BUS: begin
        if (rx_valid_q) err_d = 1'b1;
        if (!HLT) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          be_d      = 4'h0;
          p_state_d = P_RESP;
          if (cmd_wr_q) begin
            resp_d      = {RESP_OK, 24'h0};
            resp_left_d = 3'd1;
          end else begin
            resp_d      = DATAI;
            resp_left_d = 3'd4;
          end
        end
      end
      default: begin
        if (rx_valid_q) err_d = 1'b1;
        if (resp_left_q != 3'd0) begin
          tx_load = 1'b1;
          if (tx_ready) begin
            resp_d      = {resp_q[23:0], 8'h00};
            resp_left_d = resp_left_q - 3'd1;
          end
        end else if (tx_done) begin
          p_state_d = P_IDLE;
        end
      end
    endcase

    // Strobes go up on the same edge that enters BUS, using the just-completed fields.
    if (p_state_d == P_BUS && p_state_q != P_BUS) begin
      rd_d    = !cmd_wr_q;
      wr_d    = cmd_wr_q;
      be_d    = 4'hF;
      addr_d  = {addr_sh_d[31:2], 2'b00};
      datao_d = data_sh_d;
    end

`ifdef UART_DBG_TIMEOUT_EN
    to_cnt_d = '0;
    if ((p_state_q == P_ADDR || p_state_q == P_DATA) && !rx_valid_q) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        p_state_d = P_IDLE;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      p_state_q   <= P_IDLE;
      cmd_wr_q    <= 1'b0;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      addr_q      <= '0;
      datao_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      be_q        <= 4'h0;
      err_q       <= 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      p_state_q   <= p_state_d;
      cmd_wr_q    <= cmd_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      addr_q      <= addr_d;
      datao_q     <= datao_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      err_q       <= err_d;
`ifdef UART_DBG_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign TXD    = txd_q;
  assign ADDR   = addr_q;
  assign RD     = rd_q;
  assign WR     = wr_q;
  assign BE     = be_q;
  assign DATAO  = datao_q;
  assign ACTIVE = (p_state_q != P_IDLE);
  assign ERR    = err_q;

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master: serial frames in, bus accesses and serial replies checked.
`timescale 1ns/1ps
module tb_uart_dbg_master;
  localparam int BAUD    = 8;
  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] addr;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] datao;
  logic [31:0] datai = 32'h0;
  logic        hlt = 1'b0;
  logic        active, err;

  always #5 clk = ~clk;

  uart_dbg_master #(.BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RES(rst_n), .RXD(rxd), .TXD(txd), .ADDR(addr), .RD(rd), .WR(wr),
    .BE(be), .DATAO(datao), .DATAI(datai), .HLT(hlt), .ACTIVE(active), .ERR(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serial decoder on TXD, sampling mid-bit
  logic [7:0] rx_q[$];
  time        rx_t[$];
  int         tx_ferr = 0;
  logic       txd_prev = 1'b1;
  logic [7:0] mon_b;
  time        mon_t0;

  always begin
    @(negedge clk);
    if (rst_n && txd_prev && !txd) begin
      mon_t0 = $time;
      repeat (BAUD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        mon_b[i] = txd;
      end
      repeat (BAUD) @(negedge clk);
      if (!txd) tx_ferr++;
      rx_q.push_back(mon_b);
      rx_t.push_back(mon_t0);
    end
    txd_prev = txd;
  end

  // Bus slave: memory model plus access recorder; HLT held for hold_n cycles per access
  int          hold_n = 0;
  int          acc_len = 0;
  int          n_acc = 0;
  int          last_len = 0;
  int          acc_bad = 0;
  int          n_err = 0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] acc_data = 32'h0;
  logic        acc_wr = 1'b0;
  bit          in_acc = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h2000) ? 32'h12345678 : {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (err === 1'b1) n_err++;
    if (rd || wr) begin
      if (!in_acc) begin
        in_acc   = 1'b1;
        acc_len  = 0;
        acc_addr = addr;
        acc_data = datao;
        acc_wr   = wr;
      end
      acc_len++;
      if (be !== 4'hF || addr !== acc_addr || datao !== acc_data || wr !== acc_wr || (rd && wr))
        acc_bad++;
      hlt   = (acc_len <= hold_n);
      datai = mem_rd(addr);
    end else begin
      if (in_acc) begin
        in_acc   = 1'b0;
        n_acc++;
        last_len = acc_len;
      end
      hlt   = 1'b0;
      datai = 32'h0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd = stop;
    repeat (BAUD) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (2 * BAUD) @(negedge clk);
  endtask

  typedef struct {
    int          nb;
    logic [71:0] tx;
    int          hold;
    int          exp_nacc;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_len;
    int          nresp;
    logic [31:0] resp;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_stats();
    rx_q.delete();
    rx_t.delete();
    n_err    = 0;
    n_acc    = 0;
    last_len = 0;
    acc_bad  = 0;
    tx_ferr  = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] b;
    clear_stats();
    hold_n = v.hold;
    for (int i = 0; i < v.nb; i++) begin
      b = v.tx[71 - 8 * i -: 8];
      send_byte(b, 1'b1);
    end
    for (int c = 0; c < 3000 && rx_q.size() < v.nresp; c++) @(negedge clk);
    chk($sformatf("v%0d resp_count", idx), 32'(rx_q.size()), 32'(v.nresp));
    chk($sformatf("v%0d active_in_last_stop", idx), 32'(active), 32'd1);
    for (int c = 0; c < 2 * BAUD && active; c++) @(negedge clk);
    chk($sformatf("v%0d active_after_stop", idx), 32'(active), 32'd0);
    for (int i = 0; i < v.nresp && i < rx_q.size(); i++) begin
      b = v.resp[31 - 8 * i -: 8];
      chk($sformatf("v%0d resp_byte%0d", idx, i), 32'(rx_q[i]), 32'(b));
    end
    for (int i = 1; i < rx_t.size(); i++)
      chk($sformatf("v%0d char_spacing%0d", idx, i), 32'(rx_t[i] - rx_t[i-1]), 32'(10 * BAUD * 10));
    chk($sformatf("v%0d n_access", idx), 32'(n_acc), 32'(v.exp_nacc));
    if (v.exp_nacc != 0) begin
      chk($sformatf("v%0d addr", idx), acc_addr, v.exp_addr);
      chk($sformatf("v%0d is_write", idx), 32'(acc_wr), 32'(v.exp_wr));
      chk($sformatf("v%0d strobe_cycles", idx), 32'(last_len), 32'(v.exp_len));
      chk($sformatf("v%0d bus_stable", idx), 32'(acc_bad), 32'd0);
      if (v.exp_wr) chk($sformatf("v%0d wdata", idx), acc_data, v.exp_data);
    end
    chk($sformatf("v%0d err_pulses", idx), 32'(n_err), 32'(v.exp_err));
    chk($sformatf("v%0d tx_stop_bits", idx), 32'(tx_ferr), 32'd0);
    $display("frame %0d: %0d bytes in, %0d bytes out, accesses=%0d len=%0d addr=%h err=%0d",
             idx, v.nb, rx_q.size(), n_acc, last_len, acc_addr, n_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{9, 72'h57000010_04DEADBEEF, 0, 1, 1'b1, 32'h00001004, 32'hDEADBEEF, 1, 1, 32'h4B000000, 0};
    vecs[1] = '{5, 72'h52000020_0300000000, 3, 1, 1'b0, 32'h00002000, 32'h00000000, 4, 4, 32'h12345678, 0};
    vecs[2] = '{1, 72'h41000000_0000000000, 0, 0, 1'b0, 32'h00000000, 32'h00000000, 0, 1, 32'h3F000000, 1};
    vecs[3] = '{9, 72'h57800000_FF01020304, 2, 1, 1'b1, 32'h800000FC, 32'h01020304, 3, 1, 32'h4B000000, 0};
    vecs[4] = '{5, 72'h52000030_0000000000, 0, 1, 1'b0, 32'h00003000, 32'h00000000, 1, 4, 32'h3000CFFF, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset TXD", 32'(txd), 32'd1);
    chk("reset RD_WR", {30'h0, rd, wr}, 32'd0);
    chk("reset BE", 32'(be), 32'd0);
    chk("reset ADDR", addr, 32'h0);
    chk("reset DATAO", datao, 32'h0);
    chk("reset ACTIVE_ERR", {30'h0, active, err}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("reset released");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Framing error: byte discarded, parser stays idle, then a normal write
    clear_stats();
    send_byte(8'h55, 1'b0);
    repeat (4 * BAUD) @(negedge clk);
    chk("ferr err_pulses", 32'(n_err), 32'd1);
    chk("ferr active", 32'(active), 32'd0);
    chk("ferr no_access", 32'(n_acc), 32'd0);
    $display("framing-error byte 55: err=%0d active=%0d", n_err, active);
    run_vec(vecs[0], 5);

    // Partial frame followed by silence
    clear_stats();
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("partial active", 32'(active), 32'd1);
    repeat (TIMEOUT + 100) @(negedge clk);
`ifdef UART_DBG_TIMEOUT_EN
    chk("timeout err_pulses", 32'(n_err), 32'd1);
    chk("timeout active", 32'(active), 32'd0);
`else
    chk("no_timeout err_pulses", 32'(n_err), 32'd0);
    chk("no_timeout active", 32'(active), 32'd1);
`endif
    chk("partial no_reply", 32'(rx_q.size()), 32'd0);
    chk("partial txd_idle", 32'(txd), 32'd1);
    chk("partial no_access", 32'(n_acc), 32'd0);
    $display("partial frame 52 00: active=%0d err=%0d", active, n_err);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted while a read is held off by HLT
    clear_stats();
    hold_n = 1000000;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int c = 0; c < 100 && !rd; c++) @(negedge clk);
    chk("stuck rd_up", 32'(rd), 32'd1);
    repeat (5) @(negedge clk);
    chk("stuck rd_held", 32'(rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset RD_WR", {30'h0, rd, wr}, 32'd0);
    chk("async_reset BE", 32'(be), 32'd0);
    chk("async_reset TXD", 32'(txd), 32'd1);
    chk("async_reset ACTIVE", 32'(active), 32'd0);
    $display("reset during held read: rd=%0d be=%h active=%0d", rd, be, active);
    repeat (3) @(negedge clk);
    hold_n = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_vec(vecs[1], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
